// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: MISALIGN_TRAP_EN.
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;

    localparam logic [INST_W-1:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [ADDR_W-1:0] PC_STEP     = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Clears the byte-offset bits so a loaded PC is always word aligned.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

    // Sequential fetch address; wraps naturally at 2^64.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // True when the fetched word is the halting breakpoint.
    function automatic logic is_ebreak(input logic [INST_W-1:0] inst);
        return (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch queue: synchronous FIFO of {pc, inst} pairs with flush.
// Flush beats push/pop. A push while full is only legal together with a pop;
// the writer lands in the slot being freed. Head outputs read 0 when empty.
import inst_fetch_pkg::*;

module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic [PTR_W:0]    count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_inst
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              valid_s;

    assign valid_s    = (count_r != {(PTR_W+1){1'b0}});
    assign count      = count_r;
    assign head_valid = valid_s;
    assign head_pc    = valid_s ? pc_mem_r[rd_ptr_r]   : {ADDR_W{1'b0}};
    assign head_inst  = valid_s ? inst_mem_r[rd_ptr_r] : {INST_W{1'b0}};

    // Storage write: one entry per accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
                inst_mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (push && !flush) begin
            pc_mem_r[wr_ptr_r]   <= push_pc;
            inst_mem_r[wr_ptr_r] <= push_inst;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// PC generation and fetch buffer between instruction memory and decode.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect
// targets (enter HALT, report out_misalign/out_misalign_pc). Without it the
// low two bits of a redirect target are dropped.
import inst_fetch_pkg::*;

module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_done_load_inst,
    output logic [63:0] out_inst_addr,
    input  logic [31:0] in_inst,
    input  logic        in_redirect_valid,
    input  logic [63:0] in_redirect_pc,
    output logic        out_fetch_valid,
    input  logic        in_fetch_ready,
    output logic [31:0] out_fetch_inst,
    output logic [63:0] out_fetch_pc,
    output logic        out_halted
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        out_misalign,
    output logic [63:0] out_misalign_pc
`endif
);

    localparam int             PTR_W    = $clog2(FQ_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FQ_DEPTH);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] pc_r;

    logic [PTR_W:0]    count_s;
    logic              fetch_valid_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic [INST_W-1:0] head_inst_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              redirect_s;
    logic              misalign_hit_s;
    logic [ADDR_W-1:0] redirect_target_s;

`ifdef MISALIGN_TRAP_EN
    logic              misalign_r;
    logic [ADDR_W-1:0] misalign_pc_r;

    assign out_misalign    = misalign_r;
    assign out_misalign_pc = misalign_pc_r;
`endif

    assign out_inst_addr   = pc_r;
    assign out_fetch_valid = fetch_valid_s;
    assign out_fetch_pc    = head_pc_s;
    assign out_fetch_inst  = head_inst_s;
    assign out_halted      = (state_r == HALT);
    assign full_s          = (count_s == FULL_CNT);

    // Handshake and enqueue decisions; a redirect suppresses the enqueue.
    always_comb begin
        pop_s             = 1'b0;
        push_s            = 1'b0;
        redirect_s        = 1'b0;
        misalign_hit_s    = 1'b0;
        redirect_target_s = pc_r;

        pop_s      = fetch_valid_s && in_fetch_ready;
        redirect_s = in_redirect_valid && (state_r != IDLE);

`ifdef MISALIGN_TRAP_EN
        misalign_hit_s    = redirect_s && (in_redirect_pc[1:0] != 2'b00);
        redirect_target_s = in_redirect_pc;
`else
        misalign_hit_s    = 1'b0;
        redirect_target_s = align_pc(in_redirect_pc);
`endif

        if ((state_r == RUN) && !redirect_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Fetch FSM: load gating, sequential PC advance, EBREAK halt, redirects.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
            misalign_r    <= 1'b0;
            misalign_pc_r <= {ADDR_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_done_load_inst) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN, HALT: begin
                    if (redirect_s) begin
                        if (misalign_hit_s) begin
                            state_r <= HALT;
`ifdef MISALIGN_TRAP_EN
                            misalign_r    <= 1'b1;
                            misalign_pc_r <= in_redirect_pc;
`endif
                        end else begin
                            state_r <= RUN;
                            pc_r    <= redirect_target_s;
                        end
                    end else if (push_s) begin
                        pc_r <= next_pc(pc_r);
                        if (is_ebreak(in_inst)) begin
                            state_r <= HALT;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .PTR_W (PTR_W)
    ) u_fetch_queue (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .flush      (redirect_s),
        .push       (push_s),
        .pop        (pop_s),
        .push_pc    (pc_r),
        .push_inst  (in_inst),
        .count      (count_s),
        .head_valid (fetch_valid_s),
        .head_pc    (head_pc_s),
        .head_inst  (head_inst_s)
    );

endmodule
